// File: rtl/rx_fifo_pkg.sv
// Shared read-FSM state type, default parameters and byte-lane helper for rx_word_fifo.
package rx_fifo_pkg;

  localparam int DEF_BYTES      = 4;
  localparam int DEF_DEPTH_LOG2 = 10;
  localparam bit DEF_BIG_ENDIAN = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    POP  = 2'd2
  } rd_state_t;

  // Bit-lane index (in bytes) for the k-th received byte of a word.
  function automatic int byte_lane(input int k, input int bytes, input bit big_endian);
    return big_endian ? (bytes - 1 - k) : k;
  endfunction

endpackage

// File: rtl/rx_word_fifo_rise_pulse.sv
// Rising-edge detector: registered one-cycle strobe one clock after i_lvl goes high.
module rise_pulse (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_lvl,
  output logic o_pulse
);

  logic r_hist;
  logic r_pulse;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hist  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_hist  <= i_lvl;
      r_pulse <= i_lvl & ~r_hist;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/rx_word_fifo.sv
// Packs received bytes into words and queues them; each rd_req rising edge pops one word.
// Read latency is 2 cycles from the request edge when data is present; completions while full are dropped.
module rx_word_fifo
  import rx_fifo_pkg::*;
#(
  parameter int BYTES      = DEF_BYTES,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter bit BIG_ENDIAN = DEF_BIG_ENDIAN
) (
  input  logic                 CLK,
  input  logic                 reset_n,
  input  logic [7:0]           data,
  input  logic                 valid,
  input  logic                 rd_req,
  input  logic                 clr_ovf,
  output logic [8*BYTES-1:0]   rd_data,
  output logic                 rd_ready,
  output logic [DEPTH_LOG2:0]  count,
  output logic                 full,
  output logic                 overflow
);

  localparam int W     = 8 * BYTES;
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int CNTW  = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0]   LAST_BYTE = CW'(BYTES - 1);
  localparam logic [CNTW-1:0] FULL_CNT  = CNTW'(DEPTH);

  logic [CW-1:0]         r_byte_cnt;
  logic [W-1:0]          r_asm;
  logic [DEPTH_LOG2-1:0] r_head;
  logic [DEPTH_LOG2-1:0] r_tail;
  logic [CNTW-1:0]       r_count;
  logic                  r_ovf;
  logic                  r_pend;
  logic [W-1:0]          r_rd_data;
  logic [W-1:0]          r_mem [DEPTH];
  rd_state_t             r_state;
  rd_state_t             w_nstate;

  logic [W-1:0] w_word;
  logic         w_full;
  logic         w_done;
  logic         w_wr;
  logic         w_pop;
  logic         w_load;
  logic         w_pulse;
  logic         w_req;
  logic         w_nonempty;

  rise_pulse u_req_edge (
    .i_clk   (CLK),
    .i_rst_n (reset_n),
    .i_lvl   (rd_req),
    .o_pulse (w_pulse)
  );

  // Word as it would look with the current byte merged in; written to memory on completion.
  always_comb begin
    w_word = r_asm;
    w_word[8*byte_lane(int'(r_byte_cnt), BYTES, BIG_ENDIAN) +: 8] = data;
  end

  assign w_full     = (r_count == FULL_CNT);
  assign w_nonempty = (r_count != '0);
  assign w_done     = valid && (r_byte_cnt == LAST_BYTE);
  assign w_wr       = w_done && !w_full;
  assign w_pop      = (r_state == POP);
  assign w_req      = w_pulse | r_pend;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_byte_cnt <= '0;
      r_asm      <= '0;
    end else if (valid) begin
      r_asm      <= w_word;
      r_byte_cnt <= w_done ? '0 : r_byte_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_wr) r_mem[r_head] <= w_word;
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr)  r_head <= r_head + 1'b1;
      if (w_pop) r_tail <= r_tail + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A drop decided on pre-edge count wins over a same-cycle clear.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n)              r_ovf <= 1'b0;
    else if (w_done && w_full) r_ovf <= 1'b1;
    else if (clr_ovf)          r_ovf <= 1'b0;
  end

  // A single request edge seen while busy is remembered and served on the next IDLE cycle.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n)              r_pend <= 1'b0;
    else if (r_state == IDLE)  r_pend <= 1'b0;
    else if (w_pulse)          r_pend <= 1'b1;
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n)    r_state <= IDLE;
    else             r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    w_load   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          if (w_nonempty) begin
            w_load   = 1'b1;
            w_nstate = POP;
          end else begin
            w_nstate = WAIT;
          end
        end
      end
      WAIT: begin
        if (w_nonempty) begin
          w_load   = 1'b1;
          w_nstate = POP;
        end
      end
      POP:     w_nstate = IDLE;
      default: w_nstate = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n)    r_rd_data <= '0;
    else if (w_load) r_rd_data <= r_mem[r_tail];
  end

  assign rd_data  = r_rd_data;
  assign rd_ready = w_pop;
  assign count    = r_count;
  assign full     = w_full;
  assign overflow = r_ovf;

endmodule
